ip_tx_sched: RTL

Packet-locked round-robin scheduler that shares the single PCIe core transmit interface among c_NUM_PORTS TLP sources. A grant is held from the core's tx_rdy through the end-of-packet beat, and is not re-arbitrated until a fixed drain gap has passed. Sits between the TLP generators (DMA read/write engines, completion engine, message unit) and the core TX port, replacing the stateless mux-plus-priority-select in that position.

---
 rtl/ip_tx_sched_pkg.sv | 24 ++
 rtl/ip_tx_sched_rr_pick.sv | 29 ++
 rtl/ip_tx_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ip_tx_sched_pkg.sv
// Shared definitions for the IP TX scheduler family: FSM state encoding,
// default widths and a constant clog2 helper.
package ip_tx_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int C_DATA_WIDTH_DEF = 64;
  localparam int C_NUM_PORTS_DEF  = 4;
  localparam int C_PTR_W_DEF      = 2;
  localparam int C_DRAIN_DEF      = 2;
  localparam int C_TIMEOUT_DEF    = 255;

  // Smallest r with 2**r >= v; used for counter and pointer widths.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ip_tx_sched_rr_pick.sv
// Combinational rotating-priority picker. Searches lp+1, lp+2, ... with wrap
// and returns the first requesting index. Also used by the RX credit scheduler.
module ip_rr_pick #(
  parameter int c_NUM_PORTS = 4,
  parameter int c_PTR_W     = 2
) (
  input  logic [c_NUM_PORTS-1:0] req,
  input  logic [c_PTR_W-1:0]     lp,
  output logic [c_PTR_W-1:0]     idx,
  output logic                   vld
);

  logic [c_PTR_W-1:0] p;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    p   = '0;
    for (int k = c_NUM_PORTS; k >= 1; k--) begin
      p = c_PTR_W'((int'(lp) + k) % c_NUM_PORTS);
      if (req[p]) begin
        idx = p;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_tx_sched.sv
// Packet-locked round-robin scheduler sharing the PCIe core TX port among
// c_NUM_PORTS TLP sources. Grant is held from tx_rdy through the EOP beat,
// followed by a c_DRAIN cycle gap before the next arbitration.
// Optional macro IP_TX_SCHED_TIMEOUT_EN: abort a REQ that waits c_TIMEOUT
// cycles for tx_rdy and demote the stalled port.
//
//   state   | meaning
//   IDLE    | no owner; arbitrate among pending requests
//   REQ     | owner chosen, requesting the core, waiting for tx_rdy
//   XFER    | packet in flight; beats on tx_rdy & tx_val until EOP
//   DRAIN   | post-EOP gap, tx_req held low for c_DRAIN cycles
module ip_tx_sched
  import ip_tx_pkg::*;
#(
  parameter int c_DATA_WIDTH = C_DATA_WIDTH_DEF,
  parameter int c_NUM_PORTS  = C_NUM_PORTS_DEF,
  parameter int c_PTR_W      = C_PTR_W_DEF,
  parameter int c_DRAIN      = C_DRAIN_DEF,
  parameter int c_TIMEOUT    = C_TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              tx_val,
  input  logic [c_NUM_PORTS-1:0]            tx_req_in,
  input  logic [c_NUM_PORTS*c_DATA_WIDTH-1:0] tx_din_in,
  input  logic [c_NUM_PORTS-1:0]            tx_sop_in,
  input  logic [c_NUM_PORTS-1:0]            tx_eop_in,
  input  logic [c_NUM_PORTS-1:0]            tx_dwen_in,
  output logic [c_NUM_PORTS-1:0]            tx_rdy_out,
  output logic                              tx_req,
  output logic [c_DATA_WIDTH-1:0]           tx_dout,
  output logic                              tx_sop,
  output logic                              tx_eop,
  output logic                              tx_dwen,
  input  logic                              tx_rdy,
  output logic [c_PTR_W-1:0]                grant,
  output logic                              busy,
  output logic [c_NUM_PORTS-1:0]            tx_timeout
);

  localparam int DCW = clog2_f(c_DRAIN + 1);

  logic [1:0]              state;
  logic [c_PTR_W-1:0]      lp;
  logic [DCW-1:0]          dcnt;
  logic [c_PTR_W-1:0]      pick_idx;
  logic                    pick_vld;
  logic                    active;
  logic                    beat;
  logic                    tmo;
  logic [c_DATA_WIDTH-1:0] din_a [c_NUM_PORTS];

  ip_rr_pick #(
    .c_NUM_PORTS (c_NUM_PORTS),
    .c_PTR_W     (c_PTR_W)
  ) u_pick (
    .req (tx_req_in),
    .lp  (lp),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  for (genvar i = 0; i < c_NUM_PORTS; i++) begin : g_din
    assign din_a[i] = tx_din_in[i*c_DATA_WIDTH +: c_DATA_WIDTH];
  end

  assign active  = (state == S_REQ) || (state == S_XFER);
  assign beat    = tx_rdy & tx_val;
  assign busy    = (state != S_IDLE);
  assign tx_dout = din_a[grant];
  assign tx_req  = active & tx_req_in[grant];
  assign tx_sop  = active & tx_sop_in[grant];
  assign tx_eop  = active & tx_eop_in[grant];
  assign tx_dwen = active & tx_dwen_in[grant];

  // Only the owning port sees core ready, and only while it owns the core.
  always_comb begin
    tx_rdy_out = '0;
    if (active) tx_rdy_out[grant] = tx_rdy;
  end

`ifdef IP_TX_SCHED_TIMEOUT_EN
  localparam int TCW = clog2_f(c_TIMEOUT + 1);
  logic [TCW-1:0] tmr;

  // Abort fires on the c_TIMEOUT-th REQ cycle if tx_rdy never came and the
  // port is still requesting (a withdrawal takes the quieter exit).
  assign tmo = (state == S_REQ) && !tx_rdy && tx_req_in[grant] && (tmr == '0);

  // One-cycle abort pulse on the stalled port.
  always_comb begin
    tx_timeout = '0;
    if (tmo) tx_timeout[grant] = 1'b1;
  end

  // REQ wait timer: reloaded on every REQ entry, counts down while waiting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr <= '0;
    end else if (state == S_IDLE) begin
      tmr <= TCW'(c_TIMEOUT - 1);
    end else if (state == S_REQ && tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end
`else
  localparam int unused_timeout = c_TIMEOUT;
  assign tmo        = 1'b0;
  assign tx_timeout = '0;
`endif

  // Scheduler FSM: arbitration, packet lock, drain gap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      grant <= '0;
      lp    <= c_PTR_W'(c_NUM_PORTS - 1);
      dcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant <= pick_idx;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (tx_rdy) begin
            state <= S_XFER;
          end else if (!tx_req_in[grant]) begin
            state <= S_IDLE;
          end else if (tmo) begin
            state <= S_IDLE;
            lp    <= grant;
          end
        end
        S_XFER: begin
          if (beat && tx_eop_in[grant]) begin
            state <= S_DRAIN;
            lp    <= grant;
            dcnt  <= DCW'(c_DRAIN - 1);
          end
        end
        default: begin
          if (dcnt == '0) state <= S_IDLE;
          else            dcnt  <= dcnt - 1'b1;
        end
      endcase
    end
  end

endmodule
